// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: opcodes, FSM state encoding and flag register layout shared by the sequencer and its bench
package pc_sequencer_pkg;
  localparam logic [3:0] OP_BNE  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_UPDATE = 3'd3,
    S_HALTED = 3'd4
  } state_t;
  typedef struct packed {
    logic zero;
    logic negative;
  } flags_t;
endpackage

// File: rtl/pc_sequencer_branch_unit.sv
// branch_unit: combinational branch condition evaluation from opcode and stored flags
module branch_unit
  import pc_sequencer_pkg::*;
(
  input  logic [3:0] opcode,
  input  flags_t     flags,
  output logic       taken
);
  assign taken = (opcode == OP_JMP) | ((opcode == OP_BNE) & ~flags.zero);
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/issue/complete control loop owning the PC, flags and retired count
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int PC_WIDTH     = 10,
  parameter int INSTR_WIDTH  = 18,
  parameter int OPCODE_WIDTH = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  output logic                   o_imem_req,
  output logic [PC_WIDTH-1:0]    o_imem_addr,
  input  logic                   i_imem_valid,
  input  logic [INSTR_WIDTH-1:0] i_imem_data,
  output logic                   o_issue_valid,
  output logic [INSTR_WIDTH-1:0] o_instr,
  input  logic                   i_ex_done,
  input  logic                   i_flags_we,
  input  logic                   i_zero,
  input  logic                   i_negative,
  output logic [PC_WIDTH-1:0]    o_pc,
  output logic                   o_branch_taken,
  output logic                   o_halted,
  output logic [CNT_WIDTH-1:0]   o_retired
);
  state_t state;
  flags_t flags, flags_nxt;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic taken;
  assign opcode = o_instr[INSTR_WIDTH-1 -: OPCODE_WIDTH];
  assign o_imem_addr = o_pc;
  // Evaluated on the EXEC exit edge with the flags being written, so the taken pulse is registered into UPDATE
  assign flags_nxt = (state == S_EXEC && i_ex_done && i_flags_we) ? flags_t'({i_zero, i_negative}) : flags;
  branch_unit u_branch (
    .opcode (opcode),
    .flags  (flags_nxt),
    .taken  (taken)
  );
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= S_IDLE;
      o_pc           <= '0;
      o_instr        <= '0;
      flags          <= '0;
      o_retired      <= '0;
      o_imem_req     <= 1'b0;
      o_issue_valid  <= 1'b0;
      o_branch_taken <= 1'b0;
      o_halted       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (i_start) begin
          state      <= S_FETCH;
          o_imem_req <= 1'b1;
        end
        S_FETCH: if (i_imem_valid) begin
          state         <= S_EXEC;
          o_instr       <= i_imem_data;
          o_imem_req    <= 1'b0;
          o_issue_valid <= 1'b1;
        end
        S_EXEC: if (i_ex_done) begin
          state          <= S_UPDATE;
          flags          <= flags_nxt;
          o_issue_valid  <= 1'b0;
          o_branch_taken <= taken;
        end
        S_UPDATE: begin
          o_pc           <= o_branch_taken ? o_instr[PC_WIDTH-1:0] : o_pc + 1'b1;
          o_retired      <= o_retired + 1'b1;
          o_branch_taken <= 1'b0;
          state          <= (opcode == OP_HALT) ? S_HALTED : S_FETCH;
          o_imem_req     <= opcode != OP_HALT;
          o_halted       <= opcode == OP_HALT;
        end
        S_HALTED: state <= S_HALTED;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table-driven and randomized checks of pc_sequencer against a flag/PC/count model
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;
  logic clk = 0, rst = 0, start = 0, imem_valid = 0, ex_done = 0, flags_we = 0, zero = 0, negative = 0;
  logic [17:0] imem_data = '0;
  logic imem_req, issue_valid, branch_taken, halted;
  logic [9:0] imem_addr, pc;
  logic [17:0] instr;
  logic [15:0] retired;
  int total = 0, bad = 0;
  always #5 clk = ~clk;

  pc_sequencer dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr),
    .i_imem_valid(imem_valid), .i_imem_data(imem_data),
    .o_issue_valid(issue_valid), .o_instr(instr),
    .i_ex_done(ex_done), .i_flags_we(flags_we), .i_zero(zero), .i_negative(negative),
    .o_pc(pc), .o_branch_taken(branch_taken), .o_halted(halted), .o_retired(retired)
  );

  typedef struct {
    logic [17:0] ins;
    int fw;
    int ew;
    bit fwe;
    bit z;
    bit tk;
    logic [9:0] npc;
  } vec_t;

  function automatic logic [17:0] mk(input logic [3:0] op, input logic [9:0] tgt);
    return {op, 4'b0, tgt};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Entered at a negedge with the DUT in FETCH; leaves at the negedge after UPDATE
  task automatic run_instr(input logic [17:0] ins, input int fw, input int ew, input bit fwe, input bit z,
                           output bit tk, output logic [9:0] npc);
    logic [9:0] a0;
    a0 = imem_addr;
    chk("fetch_req", imem_req, 1);
    chk("addr_is_pc", imem_addr, pc);
    for (int i = 0; i < fw; i++) begin
      ex_done = 1'($urandom_range(0, 1));
      flags_we = 1'b1;
      zero = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("addr_stable", imem_addr, a0);
      chk("stall_req", imem_req, 1);
      chk("stall_no_issue", issue_valid, 0);
    end
    ex_done = 0;
    flags_we = 0;
    imem_valid = 1;
    imem_data = ins;
    @(negedge clk);
    imem_valid = 0;
    imem_data = 18'($urandom);
    chk("issue_valid", issue_valid, 1);
    chk("instr", instr, ins);
    chk("req_low_exec", imem_req, 0);
    for (int i = 0; i < ew; i++) begin
      imem_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("issue_hold", issue_valid, 1);
      chk("instr_hold", instr, ins);
      chk("pc_hold_exec", pc, a0);
    end
    imem_valid = 0;
    ex_done = 1;
    flags_we = fwe;
    zero = z;
    negative = 1'($urandom_range(0, 1));
    @(negedge clk);
    ex_done = 0;
    flags_we = 0;
    chk("update_no_issue", issue_valid, 0);
    chk("pc_hold_update", pc, a0);
    tk = branch_taken;
    @(negedge clk);
    chk("taken_one_cycle", branch_taken, 0);
    npc = pc;
  endtask

  vec_t tbl[10];
  bit tk, mz;
  logic [9:0] npc, mpc, tgt;
  logic [15:0] mret;
  logic [3:0] op;
  bit etk, fwe, z;

  initial begin
    tbl[0] = '{mk(4'h1, 10'h0),   0, 0, 0, 0, 0, 10'd1};
    tbl[1] = '{mk(4'h2, 10'h0),   0, 0, 0, 0, 0, 10'd2};
    tbl[2] = '{mk(4'h3, 10'h0),   0, 0, 0, 0, 0, 10'd3};
    tbl[3] = '{mk(4'h4, 10'h0),   0, 0, 1, 0, 0, 10'd4};
    tbl[4] = '{mk(OP_BNE, 10'h5), 0, 0, 0, 0, 1, 10'd5};
    tbl[5] = '{mk(4'h4, 10'h0),   0, 0, 1, 1, 0, 10'd6};
    tbl[6] = '{mk(OP_BNE, 10'h5), 0, 0, 0, 0, 0, 10'd7};
    tbl[7] = '{mk(OP_JMP, 10'h3FF), 0, 0, 0, 0, 1, 10'h3FF};
    tbl[8] = '{mk(4'h5, 10'h0),   4, 2, 0, 0, 0, 10'd0};
    tbl[9] = '{mk(OP_BNE, 10'h7), 2, 1, 1, 0, 1, 10'd7};

    rst = 1;
    repeat (2) @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_issue", issue_valid, 0);
    chk("rst_taken", branch_taken, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pc", pc, 0);
    chk("rst_instr", instr, 0);
    chk("rst_retired", retired, 0);
    rst = 0;
    @(negedge clk);
    chk("idle_no_req", imem_req, 0);
    start = 1;
    @(negedge clk);
    start = 0;
    chk("start_req", imem_req, 1);
    chk("start_pc", pc, 0);
    chk("start_retired", retired, 0);

    mz = 0;
    mret = 0;
    for (int r = 0; r < 10; r++) begin
      run_instr(tbl[r].ins, tbl[r].fw, tbl[r].ew, tbl[r].fwe, tbl[r].z, tk, npc);
      mret++;
      chk($sformatf("tbl%0d_taken", r), tk, tbl[r].tk);
      chk($sformatf("tbl%0d_pc", r), npc, tbl[r].npc);
      chk($sformatf("tbl%0d_retired", r), retired, mret);
    end
    mpc = 10'd7;

    for (int r = 0; r < 60; r++) begin
      case ($urandom_range(0, 3))
        0: op = OP_BNE;
        1: op = OP_JMP;
        default: op = 4'($urandom_range(0, 9));
      endcase
      tgt = 10'($urandom);
      fwe = 1'($urandom_range(0, 1));
      z = 1'($urandom_range(0, 1));
      run_instr(mk(op, tgt), $urandom_range(0, 3), $urandom_range(0, 3), fwe, z, tk, npc);
      if (fwe) mz = z;
      etk = (op == OP_JMP) || (op == OP_BNE && !mz);
      mpc = etk ? tgt : mpc + 10'd1;
      mret++;
      chk("rnd_taken", tk, etk);
      chk("rnd_pc", npc, mpc);
      chk("rnd_retired", retired, mret);
    end

    run_instr(mk(OP_HALT, 10'h2A), 1, 1, 0, 0, tk, npc);
    mpc = mpc + 10'd1;
    mret++;
    chk("halt_taken", tk, 0);
    chk("halt_pc", npc, mpc);
    chk("halt_retired", retired, mret);
    for (int i = 0; i < 20; i++) begin
      start = 1'($urandom_range(0, 1));
      imem_valid = 1'($urandom_range(0, 1));
      ex_done = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("halted_flag", halted, 1);
      chk("halted_no_req", imem_req, 0);
      chk("halted_pc", pc, mpc);
    end
    start = 0;
    imem_valid = 0;
    ex_done = 0;

    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst2_halted", halted, 0);
    start = 1;
    @(negedge clk);
    start = 0;
    run_instr(mk(4'h4, 10'h0), 0, 0, 1, 1, tk, npc);
    chk("pre_mid_pc", npc, 1);
    imem_valid = 1;
    imem_data = mk(4'h6, 10'h0);
    @(negedge clk);
    imem_valid = 0;
    chk("mid_issue", issue_valid, 1);
    rst = 1;
    ex_done = 1;
    @(negedge clk);
    rst = 0;
    imem_valid = 1;
    @(negedge clk);
    ex_done = 0;
    imem_valid = 0;
    chk("mid_idle_req", imem_req, 0);
    chk("mid_idle_issue", issue_valid, 0);
    chk("mid_idle_taken", branch_taken, 0);
    chk("mid_pc", pc, 0);
    chk("mid_retired", retired, 0);
    start = 1;
    @(negedge clk);
    start = 0;
    run_instr(mk(OP_BNE, 10'h9), 0, 0, 0, 0, tk, npc);
    chk("mid_flags_cleared_taken", tk, 1);
    chk("mid_flags_cleared_pc", npc, 9);
    chk("mid_retired_after", retired, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
